// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader_pkg
//  Description : Shared state encoding and width defaults for the boot-time
//                program loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    localparam int c_word_width  = 16;
    localparam int c_addr_width  = 16;
    localparam int c_state_width = 3;

    typedef enum logic [c_state_width-1:0] {
        CNT_HI  = 3'd0,
        CNT_LO  = 3'd1,
        WORD_HI = 3'd2,
        WORD_LO = 3'd3,
        DONE    = 3'd4,
        ERROR   = 3'd5
    } state_t;

endpackage : prog_loader_pkg
`default_nettype wire

// File: rtl/prog_loader_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : loader_timeout
//  Description : Loadable idle down-counter. Loaded with TIMEOUT whenever a
//                byte arrives, decrements while enabled, and flags expiry on
//                the TIMEOUT-th consecutive idle cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module loader_timeout #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_load,
    input  logic i_clear,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_load_val = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    // Reload on every byte, park at zero when the loader is not waiting mid-frame
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_load_val;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // A byte arriving in the final idle cycle wins over expiry
    assign o_expire = i_en && !i_load && !i_clear && (r_cnt == CNT_W'(1));

endmodule : loader_timeout
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Boot-time program loader. Receives a byte stream (16-bit
//                word count followed by that many words, high byte first),
//                writes each word through memory port A and holds the CPU in
//                reset until the full image is written.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int WIDTH     = c_word_width,
    parameter int ADDR_W    = c_addr_width,
    parameter int BASE_ADDR = 0,
    parameter int MEM_DEPTH = 1024,
    parameter int TIMEOUT   = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_data,
    output logic              mem_we,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W-1:0] c_base      = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       c_max_words = 32'(MEM_DEPTH - BASE_ADDR);

    state_t              r_state;
    logic [15:0]         r_count;
    logic [15:0]         r_idx;
    logic [7:0]          r_hi;
    logic [ADDR_W-1:0]   r_addr;
    logic [WIDTH-1:0]    r_data;
    logic                r_we;
    logic                r_cpu_reset;
    logic                r_done;
    logic                r_error;

    logic                w_active;
    logic                w_load;
    logic                w_clear;
    logic                w_expire;
    logic [15:0]         w_n;
    logic [15:0]         w_idx_next;

    // Idle timing only matters once a frame has begun and before it ends
    assign w_active   = (r_state == CNT_LO) || (r_state == WORD_HI) || (r_state == WORD_LO);
    assign w_load     = rx_valid && (w_active || (r_state == CNT_HI));
    assign w_clear    = !w_active && !w_load;
    assign w_n        = {r_count[15:8], rx_data};
    assign w_idx_next = r_idx + 16'd1;

    loader_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_active),
        .i_load   (w_load),
        .i_clear  (w_clear),
        .o_expire (w_expire)
    );

    // Frame parser, word packer and port-A write generator
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= CNT_HI;
            r_count     <= '0;
            r_idx       <= '0;
            r_hi        <= '0;
            r_addr      <= c_base;
            r_data      <= '0;
            r_we        <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse unless re-armed below
            r_we <= 1'b0;
            case (r_state)
                CNT_HI: begin
                    if (rx_valid) begin
                        r_count[15:8] <= rx_data;
                        r_state       <= CNT_LO;
                    end
                end
                CNT_LO: begin
                    if (rx_valid) begin
                        r_count <= w_n;
                        if (w_n == 16'd0) begin
                            r_state     <= DONE;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else if ({16'd0, w_n} > c_max_words) begin
                            r_state <= ERROR;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= WORD_HI;
                        end
                    end else if (w_expire) begin
                        r_state <= ERROR;
                        r_error <= 1'b1;
                    end
                end
                WORD_HI: begin
                    if (rx_valid) begin
                        r_hi    <= rx_data;
                        r_state <= WORD_LO;
                    end else if (w_expire) begin
                        r_state <= ERROR;
                        r_error <= 1'b1;
                    end
                end
                WORD_LO: begin
                    if (rx_valid) begin
                        r_we   <= 1'b1;
                        r_data <= WIDTH'({r_hi, rx_data});
                        r_addr <= c_base + ADDR_W'(r_idx);
                        r_idx  <= w_idx_next;
                        // done follows one cycle after the final write pulse
                        r_state <= (w_idx_next == r_count) ? DONE : WORD_HI;
                    end else if (w_expire) begin
                        // Partial word is dropped, never written
                        r_state <= ERROR;
                        r_error <= 1'b1;
                    end
                end
                DONE: begin
                    r_done      <= 1'b1;
                    r_cpu_reset <= 1'b0;
                end
                ERROR: begin
                    r_error     <= 1'b1;
                    r_cpu_reset <= 1'b1;
                end
                default: begin
                    r_state <= ERROR;
                    r_error <= 1'b1;
                end
            endcase
        end
    end

    assign mem_addr  = r_addr;
    assign mem_data  = r_data;
    assign mem_we    = r_we;
    assign cpu_reset = r_cpu_reset;
    assign done      = r_done;
    assign error     = r_error;

endmodule : prog_loader
`default_nettype wire
